// File: rtl/byte_serializer.sv
// Parallel-in/serial-out word serializer, MSB first, with a one-entry holding
// register so consecutive words stream without idle cycles between frames.
module byte_serializer #(
    parameter int   WIDTH      = 8,
    parameter logic IDLE_LEVEL = 1'b0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_valid,
    output logic             in_ready,
    output logic             ser_out,
    output logic             ser_valid,
    output logic             frame_start,
    output logic             frame_end,
    output logic             busy
);

    localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;

    localparam logic [0:0] S_IDLE  = 1'b0;
    localparam logic [0:0] S_SHIFT = 1'b1;

    logic [0:0]       state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] shreg_q, shreg_d;
    logic [WIDTH-1:0] hold_q, hold_d;
    logic             hold_full_q, hold_full_d;
    logic             ser_out_q, ser_out_d;
    logic             ser_valid_q, ser_valid_d;
    logic             fs_q, fs_d;
    logic             fe_q, fe_d;

    logic             accept;
    logic             last_bit;
    logic             load_en;
    logic [WIDTH-1:0] load_word;

    assign accept   = in_valid && !hold_full_q;
    assign last_bit = (state_q == S_SHIFT) && (cnt_q == CW'(WIDTH - 1));

    // Pick the word that enters the shifter: the held word always wins over a
    // fresh one, and a fresh one only bypasses when the shifter is free.
    always_comb begin
        load_en   = 1'b0;
        load_word = in_data;
        if (state_q == S_IDLE) begin
            load_en = accept;
        end else if (last_bit) begin
            if (hold_full_q) begin
                load_en   = 1'b1;
                load_word = hold_q;
            end else begin
                load_en = accept;
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        shreg_d     = shreg_q;
        hold_d      = hold_q;
        hold_full_d = hold_full_q;
        ser_out_d   = IDLE_LEVEL;
        ser_valid_d = 1'b0;
        fs_d        = 1'b0;
        fe_d        = 1'b0;

        if (load_en) begin
            state_d     = S_SHIFT;
            cnt_d       = '0;
            shreg_d     = load_word << 1;
            ser_out_d   = load_word[WIDTH-1];
            ser_valid_d = 1'b1;
            fs_d        = 1'b1;
            if (last_bit && hold_full_q) begin
                hold_full_d = 1'b0;
            end
        end else if (state_q == S_SHIFT) begin
            if (last_bit) begin
                state_d = S_IDLE;
                cnt_d   = '0;
            end else begin
                cnt_d       = cnt_q + 1'b1;
                shreg_d     = shreg_q << 1;
                ser_out_d   = shreg_q[WIDTH-1];
                ser_valid_d = 1'b1;
                fe_d        = (cnt_q == CW'(WIDTH - 2));
            end
        end

        // Words arriving mid-frame park in the holding register.
        if (accept && (state_q == S_SHIFT) && !last_bit) begin
            hold_d      = in_data;
            hold_full_d = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            shreg_q     <= '0;
            hold_q      <= '0;
            hold_full_q <= 1'b0;
            ser_out_q   <= IDLE_LEVEL;
            ser_valid_q <= 1'b0;
            fs_q        <= 1'b0;
            fe_q        <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            shreg_q     <= shreg_d;
            hold_q      <= hold_d;
            hold_full_q <= hold_full_d;
            ser_out_q   <= ser_out_d;
            ser_valid_q <= ser_valid_d;
            fs_q        <= fs_d;
            fe_q        <= fe_d;
        end
    end

    assign in_ready    = !hold_full_q;
    assign ser_out     = ser_out_q;
    assign ser_valid   = ser_valid_q;
    assign frame_start = fs_q;
    assign frame_end   = fe_q;
    assign busy        = (state_q == S_SHIFT) || hold_full_q;

endmodule

// File: tb/tb_byte_serializer.sv
// Testbench for byte_serializer: directed scenarios plus random traffic,
// checked against a word-queue model of the serial stream.
module tb_byte_serializer;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         reset;
    logic [W-1:0] in_data;
    logic         in_valid;
    logic         in_ready;
    logic         ser_out;
    logic         ser_valid;
    logic         frame_start;
    logic         frame_end;
    logic         busy;

    byte_serializer #(.WIDTH(W), .IDLE_LEVEL(1'b0)) dut (
        .clk         (clk),
        .reset       (reset),
        .in_data     (in_data),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .ser_out     (ser_out),
        .ser_valid   (ser_valid),
        .frame_start (frame_start),
        .frame_end   (frame_end),
        .busy        (busy)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Model: the word on the wire, how many of its bits remain (including the
    // one currently driven), and words accepted but not yet started.
    logic [W-1:0] cur;
    int           rem;
    logic [W-1:0] pend[$];
    logic [W-1:0] deser;
    logic         last_acc;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic logic exp_ready();
        return pend.size() == 0;
    endfunction

    task automatic model_reset();
        pend.delete();
        rem   = 0;
        cur   = '0;
        deser = '0;
    endtask

    task automatic check_outputs();
        chk("ser_valid",   {31'b0, ser_valid},   {31'b0, rem > 0});
        chk("ser_out",     {31'b0, ser_out},     {31'b0, (rem > 0) ? cur[rem-1] : 1'b0});
        chk("frame_start", {31'b0, frame_start}, {31'b0, rem == W});
        chk("frame_end",   {31'b0, frame_end},   {31'b0, rem == 1});
        chk("busy",        {31'b0, busy},        {31'b0, (rem > 0) || (pend.size() > 0)});
        chk("in_ready",    {31'b0, in_ready},    {31'b0, exp_ready()});
        if (ser_valid) begin
            deser = {deser[W-2:0], ser_out};
            if (frame_end) chk("deser_word", {24'b0, deser}, {24'b0, cur});
        end
    endtask

    task automatic step(input logic v, input logic [W-1:0] d);
        @(negedge clk);
        in_valid = v;
        in_data  = d;
        last_acc = v && exp_ready();
        @(posedge clk);
        if (rem > 0) rem--;
        if (last_acc) pend.push_back(d);
        if (rem == 0 && pend.size() > 0) begin
            cur = pend.pop_front();
            rem = W;
        end
        #1 check_outputs();
    endtask

    task automatic drain();
        int n = 0;
        while ((rem > 0 || pend.size() > 0) && n < 100) begin
            step(1'b0, W'($urandom));
            n++;
        end
        chk("drain_timeout", {31'b0, n >= 100}, 32'd0);
    endtask

    // Present each word with in_valid held high until it is accepted.
    task automatic send_words(input logic [W-1:0] words[$]);
        int n = 0;
        while (words.size() > 0 && n < 200) begin
            step(1'b1, words[0]);
            if (last_acc) void'(words.pop_front());
            n++;
        end
        chk("send_timeout", {31'b0, n >= 200}, 32'd0);
    endtask

    initial begin
        logic [W-1:0] q[$];
        int n;

        model_reset();
        in_valid = 1'b0;
        in_data  = '0;
        reset    = 1'b1;
        #12 check_outputs();
        @(negedge clk) reset = 1'b0;

        for (int i = 0; i < 20; i++) step(1'b0, W'($urandom));

        // Single word.
        step(1'b1, 8'hA5);
        for (int i = 0; i < 10; i++) step(1'b0, 8'h00);

        // Back-to-back stream.
        q = '{8'h3C, 8'hFF, 8'h01};
        send_words(q);
        drain();

        // Backpressure: 81 waits behind a full holding register.
        q = '{8'h7E, 8'h55, 8'h81};
        send_words(q);
        drain();

        // Reset during bit 4 of F0 with a word parked in the holding register.
        step(1'b1, 8'hF0);
        step(1'b1, 8'h33);
        step(1'b0, 8'h00);
        step(1'b0, 8'h00);
        #2 reset = 1'b1;
        #1 model_reset();
        check_outputs();
        @(negedge clk) reset = 1'b0;
        step(1'b0, 8'h00);
        step(1'b1, 8'h0F);
        drain();

        // Bypass load on the frame_end edge with the holding register empty.
        step(1'b1, 8'h96);
        n = 0;
        while (rem != 1 && n < 20) begin
            step(1'b0, 8'h00);
            n++;
        end
        chk("bypass_timeout", {31'b0, n >= 20}, 32'd0);
        chk("bypass_fe", {31'b0, frame_end}, 32'd1);
        step(1'b1, 8'h69);
        chk("bypass_fs", {31'b0, frame_start}, 32'd1);
        chk("bypass_sv", {31'b0, ser_valid}, 32'd1);
        drain();

        // Random traffic; in_data wanders even when not accepted.
        for (int i = 0; i < 3000; i++) begin
            step($urandom_range(0, 99) < 60, W'($urandom));
        end
        drain();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
